// File: rtl/application_selector_cpu_oci_dct_sequencer.sv
// application_selector_cpu_oci_dct_sequencer
// Packs 2-bit trace fragments into 15-slot (30-bit) frames and hands them off
// through a single-entry frame register. When the test ends, any partial
// accumulator is drained as a short frame and the block parks in ENDED.
// Optional feature: define DCT_TIMEOUT_FLUSH_EN to flush a partial
// accumulator after TIMEOUT_CYCLES idle cycles.

module application_selector_cpu_oci_dct_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frag_valid,
  input  logic [1:0]  frag_data,
  output logic        frag_ready,
  input  logic        test_ending,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [29:0] frame_data,
  output logic [3:0]  frame_count,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        test_has_ended
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_ENDING  = 2'd1,
    S_ENDED   = 2'd2
  } state_t;

  localparam logic [3:0] SLOTS = 4'd15;

  state_t      r_state;
  state_t      w_nextState;

  logic [29:0] r_buf;
  logic [3:0]  r_count;
  logic [29:0] w_bufNext;
  logic [3:0]  w_countNext;

  logic [29:0] r_frameData;
  logic [3:0]  r_frameCount;
  logic        r_frameValid;
  logic        r_testHasEnded;

  logic        w_frameFree;
  logic        w_accFull;
  logic        w_accEmpty;
  logic        w_fragReady;
  logic        w_accept;
  logic        w_transfer;

  // Elaboration guard: the idle counter is 8 bits and must count at least once
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_badTimeout
    $error("TIMEOUT_CYCLES must be within 2..255");
  end

`ifdef DCT_TIMEOUT_FLUSH_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0]  r_idleCount;
  logic        w_timeoutHit;

  assign w_timeoutHit = (r_idleCount == TIMEOUT_LAST);
`endif

  // Next-state, handshake and transfer decisions for the sequencer
  always_comb begin
    w_frameFree = !r_frameValid || frame_ready;
    w_accFull   = (r_count == SLOTS);
    w_accEmpty  = (r_count == 4'd0);
    w_fragReady = 1'b0;
    w_transfer  = 1'b0;
    w_nextState = r_state;

    if (r_state == S_COLLECT) begin
      w_fragReady = reset_n && !(w_accFull && !w_frameFree);
    end
    w_accept = frag_valid && w_fragReady;

    case (r_state)
      S_COLLECT: begin
        if (w_frameFree && w_accFull) begin
          w_transfer = 1'b1;
        end
`ifdef DCT_TIMEOUT_FLUSH_EN
        else if (w_frameFree && w_timeoutHit && !w_accEmpty && !w_accept) begin
          w_transfer = 1'b1;
        end
`endif
        if (test_ending) begin
          w_nextState = S_ENDING;
        end
      end
      S_ENDING: begin
        if (w_frameFree && !w_accEmpty) begin
          w_transfer = 1'b1;
        end
        if (w_accEmpty && !r_frameValid) begin
          w_nextState = S_ENDED;
        end
      end
      S_ENDED: begin
        w_nextState = S_ENDED;
      end
      default: begin
        w_nextState = S_COLLECT;
      end
    endcase
  end

  // Accumulator update: a transfer empties it first, so a same-cycle fragment lands in slot 0
  always_comb begin
    w_bufNext   = r_buf;
    w_countNext = r_count;
    if (w_transfer) begin
      w_bufNext   = '0;
      w_countNext = 4'd0;
    end
    if (w_accept) begin
      w_bufNext[{w_countNext, 1'b0} +: 2] = frag_data;
      w_countNext                          = w_countNext + 4'd1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Accumulator registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf   <= '0;
      r_count <= 4'd0;
    end else begin
      r_buf   <= w_bufNext;
      r_count <= w_countNext;
    end
  end

  // Frame register: loads on transfer, otherwise holds until the consumer takes it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frameData  <= '0;
      r_frameCount <= 4'd0;
      r_frameValid <= 1'b0;
    end else if (w_transfer) begin
      r_frameData  <= r_buf;
      r_frameCount <= r_count;
      r_frameValid <= 1'b1;
    end else if (frame_ready) begin
      r_frameValid <= 1'b0;
    end
  end

  // Sticky end-of-test flag, raised on the edge that enters ENDED
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_testHasEnded <= 1'b0;
    end else begin
      r_testHasEnded <= (w_nextState == S_ENDED);
    end
  end

`ifdef DCT_TIMEOUT_FLUSH_EN
  // Idle counter: counts starved cycles with a partial accumulator, saturates at the flush point
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idleCount <= 8'd0;
    end else if (r_state != S_COLLECT || w_accept || w_transfer) begin
      r_idleCount <= 8'd0;
    end else if (!w_accEmpty && !w_timeoutHit) begin
      r_idleCount <= r_idleCount + 8'd1;
    end
  end
`endif

  assign frag_ready     = w_fragReady;
  assign frame_valid    = r_frameValid;
  assign frame_data     = r_frameData;
  assign frame_count    = r_frameCount;
  assign dct_buffer     = r_buf;
  assign dct_count      = r_count;
  assign test_has_ended = r_testHasEnded;

endmodule

// File: tb/tb_application_selector_cpu_oci_dct_sequencer.sv
// Testbench for application_selector_cpu_oci_dct_sequencer.
// Expected frames come from the list of fragments the bench has handed over:
// consecutive groups of 15, packed slot 0 first, with a trailing partial
// group drained at end of test.
// Build with DCT_TIMEOUT_FLUSH_EN defined to exercise the idle-timeout flush.

module tb_application_selector_cpu_oci_dct_sequencer;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frag_valid;
  logic [1:0]  frag_data;
  logic        frag_ready;
  logic        test_ending;
  logic        frame_valid;
  logic        frame_ready;
  logic [29:0] frame_data;
  logic [3:0]  frame_count;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;

  int vectors     = 0;
  int miscompares = 0;

  logic [1:0]  sentQ[$];
  logic [29:0] gotData[$];
  logic [3:0]  gotCount[$];

  application_selector_cpu_oci_dct_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frag_valid     (frag_valid),
    .frag_data      (frag_data),
    .frag_ready     (frag_ready),
    .test_ending    (test_ending),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .frame_data     (frame_data),
    .frame_count    (frame_count),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  // Record every frame the consumer takes, in order
  always @(negedge clk) begin
    if (reset_n === 1'b1 && frame_valid === 1'b1 && frame_ready === 1'b1) begin
      gotData.push_back(frame_data);
      gotCount.push_back(frame_count);
    end
  end

  // Pack n handed-over fragments starting at startIdx, first one in the low bits
  function automatic logic [29:0] packFrags(input int startIdx, input int n);
    logic [29:0] v;
    v = '0;
    for (int k = 0; k < n; k++) begin
      v = v | (30'(sentQ[startIdx + k]) << (2 * k));
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    frag_valid  = 1'b0;
    frag_data   = 2'd0;
    test_ending = 1'b0;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    clearInputs();
    frame_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    sentQ.delete();
    gotData.delete();
    gotCount.delete();
  endtask

  // Offer one fragment until the DUT takes it (bounded); returns at #1 after the accepting edge
  task automatic sendFrag(input logic [1:0] d, output bit ok);
    ok         = 1'b0;
    frag_valid = 1'b1;
    frag_data  = d;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (frag_ready === 1'b1) begin
        sentQ.push_back(d);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    frag_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clearInputs();
    frame_ready = 1'b1;
    tick();
    tick();
    vectors++;
    if ({frag_ready, frame_valid, frame_data, frame_count, dct_buffer, dct_count, test_has_ended} !== 71'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h, expected 0",
               {frag_ready, frame_valid, frame_data, frame_count, dct_buffer, dct_count, test_has_ended});
    end
    reset_n = 1'b1;
    tick();
    vectors++;
    if ({frag_ready, dct_count, frame_valid} !== {1'b1, 4'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL after_release: got ready=%b count=%0d fvalid=%b, expected 1 0 0",
               frag_ready, dct_count, frame_valid);
    end
  endtask

  task automatic test_full_frame();
    bit ok;
    int stalls = 0;
    doReset();
    frame_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      sendFrag(2'(i % 4), ok);
      if (!ok) stalls++;
    end
    vectors++;
    if (stalls !== 0) begin
      miscompares++;
      $display("[TB] FAIL full_stalls: got %0d stalled fragments, expected 0", stalls);
    end
    vectors++;
    if ({frame_valid, dct_count} !== {1'b0, 4'd15}) begin
      miscompares++;
      $display("[TB] FAIL full_at_15: got fvalid=%b count=%0d, expected 0 15", frame_valid, dct_count);
    end
    tick();
    vectors++;
    if ({frame_valid, frame_count, frame_data, dct_count} !== {1'b1, 4'd15, packFrags(0, 15), 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL full_frame: got v=%b n=%0d d=%h acc=%0d, expected 1 15 %h 0",
               frame_valid, frame_count, frame_data, dct_count, packFrags(0, 15));
    end
    vectors++;
    if (frame_data !== 30'h24E4E4E4) begin
      miscompares++;
      $display("[TB] FAIL full_golden: got %h, expected 24e4e4e4", frame_data);
    end
    tick();
    vectors++;
    if ({frame_valid, 32'(gotData.size())} !== {1'b0, 32'd1}) begin
      miscompares++;
      $display("[TB] FAIL full_drain: got fvalid=%b frames=%0d, expected 0 1", frame_valid, gotData.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int stalls = 0;
    int waitN  = 0;
    doReset();
    frame_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      sendFrag(2'($urandom_range(0, 3)), ok);
      if (!ok) stalls++;
    end
    vectors++;
    if (stalls !== 0) begin
      miscompares++;
      $display("[TB] FAIL bp_stalls: got %0d stalled fragments, expected 0", stalls);
    end
    vectors++;
    if ({frag_ready, dct_count, frame_valid, frame_count, frame_data} !==
        {1'b0, 4'd15, 1'b1, 4'd15, packFrags(0, 15)}) begin
      miscompares++;
      $display("[TB] FAIL bp_full: got ready=%b acc=%0d v=%b n=%0d d=%h, expected 0 15 1 15 %h",
               frag_ready, dct_count, frame_valid, frame_count, frame_data, packFrags(0, 15));
    end
    frag_valid = 1'b1;
    frag_data  = 2'($urandom_range(0, 3));
    tick();
    tick();
    tick();
    vectors++;
    if ({frag_ready, frame_valid, frame_data, dct_buffer} !== {1'b0, 1'b1, packFrags(0, 15), packFrags(15, 15)}) begin
      miscompares++;
      $display("[TB] FAIL bp_hold: got ready=%b v=%b d=%h acc=%h, expected 0 1 %h %h",
               frag_ready, frame_valid, frame_data, dct_buffer, packFrags(0, 15), packFrags(15, 15));
    end
    frag_valid  = 1'b0;
    frame_ready = 1'b1;
    while (gotData.size() < 2 && waitN < 10) begin
      tick();
      waitN++;
    end
    vectors++;
    if (gotData.size() !== 2) begin
      miscompares++;
      $display("[TB] FAIL bp_frames: got %0d frames, expected 2", gotData.size());
    end else begin
      vectors++;
      if ({gotData[0], gotCount[0], gotData[1], gotCount[1]} !==
          {packFrags(0, 15), 4'd15, packFrags(15, 15), 4'd15}) begin
        miscompares++;
        $display("[TB] FAIL bp_order: got %h/%0d %h/%0d, expected %h/15 %h/15",
                 gotData[0], gotCount[0], gotData[1], gotCount[1], packFrags(0, 15), packFrags(15, 15));
      end
    end
  endtask

  task automatic test_ending_partial();
    bit ok;
    doReset();
    frame_ready = 1'b1;
    for (int i = 0; i < 5; i++) sendFrag(2'b11, ok);
    test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    vectors++;
    if ({frag_ready, dct_count, frame_valid} !== {1'b0, 4'd5, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL end_enter: got ready=%b acc=%0d v=%b, expected 0 5 0", frag_ready, dct_count, frame_valid);
    end
    tick();
    vectors++;
    if ({frame_valid, frame_count, frame_data, dct_count} !== {1'b1, 4'd5, 30'h3FF, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL end_frame: got v=%b n=%0d d=%h acc=%0d, expected 1 5 3ff 0",
               frame_valid, frame_count, frame_data, dct_count);
    end
    tick();
    vectors++;
    if ({frame_valid, test_has_ended} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL end_accept: got v=%b ended=%b, expected 0 0", frame_valid, test_has_ended);
    end
    tick();
    vectors++;
    if (test_has_ended !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL end_flag: got %b, expected 1", test_has_ended);
    end
    frag_valid  = 1'b1;
    frag_data   = 2'b10;
    test_ending = 1'b1;
    tick();
    tick();
    tick();
    clearInputs();
    vectors++;
    if ({frag_ready, dct_count, test_has_ended, frame_valid, 32'(gotData.size())} !==
        {1'b0, 4'd0, 1'b1, 1'b0, 32'd1}) begin
      miscompares++;
      $display("[TB] FAIL ended_hold: got ready=%b acc=%0d ended=%b v=%b frames=%0d, expected 0 0 1 0 1",
               frag_ready, dct_count, test_has_ended, frame_valid, gotData.size());
    end
  endtask

  task automatic test_ending_same_cycle();
    bit ok;
    int waitN = 0;
    logic [1:0] d;
    doReset();
    frame_ready = 1'b1;
    for (int i = 0; i < 14; i++) sendFrag(2'($urandom_range(0, 3)), ok);
    d           = 2'($urandom_range(0, 3));
    frag_valid  = 1'b1;
    frag_data   = d;
    test_ending = 1'b1;
    @(negedge clk);
    vectors++;
    if (frag_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL same_ready: got %b, expected 1", frag_ready);
    end
    sentQ.push_back(d);
    tick();
    clearInputs();
    vectors++;
    if ({dct_count, frag_ready} !== {4'd15, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL same_count: got acc=%0d ready=%b, expected 15 0", dct_count, frag_ready);
    end
    tick();
    vectors++;
    if ({frame_valid, frame_count, frame_data} !== {1'b1, 4'd15, packFrags(0, 15)}) begin
      miscompares++;
      $display("[TB] FAIL same_frame: got v=%b n=%0d d=%h, expected 1 15 %h",
               frame_valid, frame_count, frame_data, packFrags(0, 15));
    end
    while (test_has_ended !== 1'b1 && waitN < 10) begin
      tick();
      waitN++;
    end
    vectors++;
    if ({test_has_ended, 32'(gotData.size())} !== {1'b1, 32'd1}) begin
      miscompares++;
      $display("[TB] FAIL same_ended: got ended=%b frames=%0d, expected 1 1", test_has_ended, gotData.size());
    end
  endtask

  task automatic test_reset_midop();
    bit ok;
    doReset();
    frame_ready = 1'b0;
    for (int i = 0; i < 22; i++) sendFrag(2'($urandom_range(1, 3)), ok);
    vectors++;
    if ({dct_count, frame_valid} !== {4'd7, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL mid_setup: got acc=%0d v=%b, expected 7 1", dct_count, frame_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({frag_ready, frame_valid, frame_data, frame_count, dct_buffer, dct_count, test_has_ended} !== 71'd0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got %h, expected 0",
               {frag_ready, frame_valid, frame_data, frame_count, dct_buffer, dct_count, test_has_ended});
    end
    tick();
    reset_n     = 1'b1;
    frame_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    vectors++;
    if ({32'(gotData.size()), dct_count, frame_valid} !== {32'd0, 4'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL mid_noemit: got frames=%0d acc=%0d v=%b, expected 0 0 0",
               gotData.size(), dct_count, frame_valid);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int firstN = 0;
    doReset();
    frame_ready = 1'b1;
    for (int i = 0; i < 3; i++) sendFrag(2'($urandom_range(0, 3)), ok);
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (frame_valid === 1'b1 && firstN == 0) firstN = n;
    end
`ifdef DCT_TIMEOUT_FLUSH_EN
    vectors++;
    if (firstN !== TO) begin
      miscompares++;
      $display("[TB] FAIL timeout_delay: got frame %0d cycles after last accept, expected %0d", firstN, TO);
    end
    vectors++;
    if (gotData.size() !== 1) begin
      miscompares++;
      $display("[TB] FAIL timeout_frames: got %0d frames, expected 1", gotData.size());
    end else begin
      vectors++;
      if ({gotCount[0], gotData[0], dct_count} !== {4'd3, packFrags(0, 3), 4'd0}) begin
        miscompares++;
        $display("[TB] FAIL timeout_frame: got n=%0d d=%h acc=%0d, expected 3 %h 0",
                 gotCount[0], gotData[0], dct_count, packFrags(0, 3));
      end
    end
`else
    vectors++;
    if ({32'(firstN), 32'(gotData.size()), dct_count, dct_buffer} !== {32'd0, 32'd0, 4'd3, packFrags(0, 3)}) begin
      miscompares++;
      $display("[TB] FAIL no_timeout: got firstN=%0d frames=%0d acc=%0d buf=%h, expected 0 0 3 %h",
               firstN, gotData.size(), dct_count, dct_buffer, packFrags(0, 3));
    end
`endif
  endtask

  task automatic test_back_to_back();
    bit prevHold = 1'b0;
    logic [29:0] holdData = '0;
    logic [3:0] holdCount = '0;
    int waitN = 0;
    int nFrames;
    int nCheck;
    int expN;
    doReset();
    for (int c = 0; c < 300; c++) begin
      frag_valid  = ($urandom_range(0, 3) != 0);
      frag_data   = 2'($urandom_range(0, 3));
      frame_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (prevHold) begin
        vectors++;
        if ({frame_valid, frame_data, frame_count} !== {1'b1, holdData, holdCount}) begin
          miscompares++;
          $display("[TB] FAIL rand_stable: got v=%b d=%h n=%0d, expected 1 %h %0d",
                   frame_valid, frame_data, frame_count, holdData, holdCount);
        end
      end
      prevHold  = frame_valid && !frame_ready;
      holdData  = frame_data;
      holdCount = frame_count;
      if (frag_valid && frag_ready) sentQ.push_back(frag_data);
      @(posedge clk);
      #1;
    end
    clearInputs();
    frame_ready = 1'b1;
    test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    while (test_has_ended !== 1'b1 && waitN < 100) begin
      tick();
      waitN++;
    end
    nFrames = (sentQ.size() + 14) / 15;
    vectors++;
    if ({test_has_ended, 32'(gotData.size())} !== {1'b1, 32'(nFrames)}) begin
      miscompares++;
      $display("[TB] FAIL rand_frames: got ended=%b frames=%0d, expected 1 %0d",
               test_has_ended, gotData.size(), nFrames);
    end
    nCheck = (gotData.size() < nFrames) ? gotData.size() : nFrames;
    for (int i = 0; i < nCheck; i++) begin
      expN = (i == nFrames - 1) ? (sentQ.size() - 15 * i) : 15;
      vectors++;
      if ({gotCount[i], gotData[i]} !== {4'(expN), packFrags(15 * i, expN)}) begin
        miscompares++;
        $display("[TB] FAIL rand_frame%0d: got n=%0d d=%h, expected %0d %h",
                 i, gotCount[i], gotData[i], expN, packFrags(15 * i, expN));
      end
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    frame_ready = 1'b0;
    clearInputs();
    test_reset();
    test_full_frame();
    test_backpressure();
    test_ending_partial();
    test_ending_same_cycle();
    test_reset_midop();
    test_timeout();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
